// File: rtl/iob_axil_arb_pkg.sv
// Shared definitions for the two-port IOb to AXI4-Lite arbiter.
// The FSM state encoding and the fixed AXI constants live here.
package iob_axil_arb_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WR      = ST_WR,
    WR_RESP = ST_WR_RESP,
    RD_ADDR = ST_RD_ADDR,
    RD_DATA = ST_RD_DATA
  } state_t;

  localparam logic [2:0] AXIL_PROT     = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/iob_axil_arb_if.sv
// Bus bundle for iob_axil_arb: two IOb requester ports plus one AXI4-Lite master.
// AXI channels transfer on a cycle where valid and ready are both high; valid never
// waits on ready and its payload holds stable until that cycle. IOb ready/rvalid are single-cycle pulses.
interface iob_axil_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              iob0_avalid_i;
  logic [ADDR_W-1:0] iob0_addr_i;
  logic [DATA_W-1:0] iob0_wdata_i;
  logic [DATA_W/8-1:0] iob0_wstrb_i;
  logic              iob0_ready_o;
  logic              iob0_rvalid_o;
  logic [DATA_W-1:0] iob0_rdata_o;

  logic              iob1_avalid_i;
  logic [ADDR_W-1:0] iob1_addr_i;
  logic [DATA_W-1:0] iob1_wdata_i;
  logic [DATA_W/8-1:0] iob1_wstrb_i;
  logic              iob1_ready_o;
  logic              iob1_rvalid_o;
  logic [DATA_W-1:0] iob1_rdata_o;

  logic              axil_awvalid_o;
  logic              axil_awready_i;
  logic [ADDR_W-1:0] axil_awaddr_o;
  logic [2:0]        axil_awprot_o;
  logic              axil_wvalid_o;
  logic              axil_wready_i;
  logic [DATA_W-1:0] axil_wdata_o;
  logic [DATA_W/8-1:0] axil_wstrb_o;
  logic              axil_bvalid_i;
  logic              axil_bready_o;
  logic [1:0]        axil_bresp_i;
  logic              axil_arvalid_o;
  logic              axil_arready_i;
  logic [ADDR_W-1:0] axil_araddr_o;
  logic [2:0]        axil_arprot_o;
  logic              axil_rvalid_i;
  logic              axil_rready_o;
  logic [DATA_W-1:0] axil_rdata_i;
  logic [1:0]        axil_rresp_i;

  logic              err_o;

  // Arbiter side: serves the IOb ports and masters the AXI4-Lite bus.
  modport master (
    input  iob0_avalid_i, iob0_addr_i, iob0_wdata_i, iob0_wstrb_i,
    output iob0_ready_o, iob0_rvalid_o, iob0_rdata_o,
    input  iob1_avalid_i, iob1_addr_i, iob1_wdata_i, iob1_wstrb_i,
    output iob1_ready_o, iob1_rvalid_o, iob1_rdata_o,
    output axil_awvalid_o, axil_awaddr_o, axil_awprot_o,
    input  axil_awready_i,
    output axil_wvalid_o, axil_wdata_o, axil_wstrb_o,
    input  axil_wready_i,
    input  axil_bvalid_i, axil_bresp_i,
    output axil_bready_o,
    output axil_arvalid_o, axil_araddr_o, axil_arprot_o,
    input  axil_arready_i,
    input  axil_rvalid_i, axil_rdata_i, axil_rresp_i,
    output axil_rready_o,
    output err_o
  );

  // Environment side: IOb requesters and the AXI4-Lite slave.
  modport slave (
    output iob0_avalid_i, iob0_addr_i, iob0_wdata_i, iob0_wstrb_i,
    input  iob0_ready_o, iob0_rvalid_o, iob0_rdata_o,
    output iob1_avalid_i, iob1_addr_i, iob1_wdata_i, iob1_wstrb_i,
    input  iob1_ready_o, iob1_rvalid_o, iob1_rdata_o,
    input  axil_awvalid_o, axil_awaddr_o, axil_awprot_o,
    output axil_awready_i,
    input  axil_wvalid_o, axil_wdata_o, axil_wstrb_o,
    output axil_wready_i,
    output axil_bvalid_i, axil_bresp_i,
    input  axil_bready_o,
    input  axil_arvalid_o, axil_araddr_o, axil_arprot_o,
    output axil_arready_i,
    output axil_rvalid_i, axil_rdata_i, axil_rresp_i,
    input  axil_rready_o,
    input  err_o
  );

endinterface

// File: rtl/iob_axil_arb_rr.sv
// Two-way arbiter: round-robin on a tie by default, fixed priority (port 0 wins)
// when IOB_AXIL_ARB_FIXED_PRIO_EN is defined.
module iob_axil_arb_rr (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

`ifdef IOB_AXIL_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^{clk_i, arst_i, update};
  assign grant = req[0] ? 2'b01 : {req[1], 1'b0};
`else
  // Port granted most recently; resets to port 1 so port 0 wins the first tie.
  logic last;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) last <= 1'b1;
    else if (update && (|req)) last <= grant[1];
  end
`endif

endmodule

// File: rtl/iob_axil_arb.sv
// Two-port IOb to AXI4-Lite master: one outstanding transaction at a time.
// Tie policy selected by IOB_AXIL_ARB_FIXED_PRIO_EN (undefined: round-robin).
module iob_axil_arb
  import iob_axil_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk_i,
  input  logic           arst_i,
  iob_axil_arb_if.master bus,
  output state_t         dbg_state
);

  state_t              state;
  logic                sel;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  logic                awvalid, wvalid, aw_done, w_done, bready, arvalid, rready, err;
  logic [1:0]          ready_q, rvalid_q;
  logic [DATA_W-1:0]   rdata0, rdata1;

  logic [1:0]          grant;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;
  logic                aw_hs, w_hs;

  iob_axil_arb_rr u_rr (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .req    ({bus.iob1_avalid_i, bus.iob0_avalid_i}),
    .update (state == IDLE),
    .grant  (grant)
  );

  assign req_addr  = grant[1] ? bus.iob1_addr_i  : bus.iob0_addr_i;
  assign req_wdata = grant[1] ? bus.iob1_wdata_i : bus.iob0_wdata_i;
  assign req_wstrb = grant[1] ? bus.iob1_wstrb_i : bus.iob0_wstrb_i;
  assign aw_hs     = awvalid & bus.axil_awready_i;
  assign w_hs      = wvalid & bus.axil_wready_i;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state    <= IDLE;
      sel      <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      bready   <= 1'b0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      ready_q  <= '0;
      rvalid_q <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
      err      <= 1'b0;
    end else begin
      ready_q  <= '0;
      rvalid_q <= '0;
      case (state)
        IDLE: if (|grant) begin
          sel     <= grant[1];
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          wstrb_q <= req_wstrb;
          if (|req_wstrb) begin
            state   <= WR;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
          end else begin
            state   <= RD_ADDR;
            arvalid <= 1'b1;
          end
        end
        // AW and W complete independently, in either order or together.
        WR: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= WR_RESP;
          end
        end
        WR_RESP: if (bus.axil_bvalid_i) begin
          bready       <= 1'b0;
          ready_q[sel] <= 1'b1;
          err          <= err | (bus.axil_bresp_i != AXI_RESP_OKAY);
          state        <= IDLE;
        end
        RD_ADDR: if (bus.axil_arready_i) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          state   <= RD_DATA;
        end
        RD_DATA: if (bus.axil_rvalid_i) begin
          rready <= 1'b0;
          if (sel) rdata1 <= bus.axil_rdata_i;
          else     rdata0 <= bus.axil_rdata_i;
          ready_q[sel]  <= 1'b1;
          rvalid_q[sel] <= 1'b1;
          err           <= err | (bus.axil_rresp_i != AXI_RESP_OKAY);
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.iob0_ready_o   = ready_q[0];
  assign bus.iob0_rvalid_o  = rvalid_q[0];
  assign bus.iob0_rdata_o   = rdata0;
  assign bus.iob1_ready_o   = ready_q[1];
  assign bus.iob1_rvalid_o  = rvalid_q[1];
  assign bus.iob1_rdata_o   = rdata1;
  assign bus.axil_awvalid_o = awvalid;
  assign bus.axil_awaddr_o  = addr_q;
  assign bus.axil_awprot_o  = AXIL_PROT;
  assign bus.axil_wvalid_o  = wvalid;
  assign bus.axil_wdata_o   = wdata_q;
  assign bus.axil_wstrb_o   = wstrb_q;
  assign bus.axil_bready_o  = bready;
  assign bus.axil_arvalid_o = arvalid;
  assign bus.axil_araddr_o  = addr_q;
  assign bus.axil_arprot_o  = AXIL_PROT;
  assign bus.axil_rready_o  = rready;
  assign bus.err_o          = err;
  assign dbg_state          = state;

endmodule
